// File: rtl/mux8to1_arbiter.sv
// Round-robin arbiter for a shared mux8to1 datapath: grants one of eight requesters and drives its select.
// Latency: one cycle from request to grant; on release the next owner is granted on the same edge.
// Backpressure: a grant is held until the owner drops req (or hold-limit preemption, if compiled in).
//
// Ports:
//   clk        - single clock, rising-edge state updates
//   reset      - asynchronous active-high reset
//   req[7:0]   - level-sensitive requests, bit i = requester i
//   gnt[7:0]   - registered one-hot grant, all zero when idle
//   sel[2:0]   - registered index of current/last owner, wired to mux8to1.sel
//   sel_valid  - high exactly when gnt is non-zero
//
// Build option: define MUX8_ARB_HOLDLIMIT_EN to enable hold-limit preemption after
// MAX_HOLD consecutive grant cycles while another requester waits.

module mux8to1_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] sel,
    output logic       sel_valid
);

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_max_hold_range
        $error("mux8to1_arbiter: MAX_HOLD must be in 2..255");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] sel_q, sel_d;
    logic [7:0] gnt_q, gnt_d;

    // {found, index}: first set bit of vec searched from base upward, wrapping 7 -> 0.
    // Iterating from the farthest offset down lets the nearest hit overwrite the result.
    function automatic logic [3:0] rr_pick(input logic [7:0] vec, input logic [2:0] base);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0;
        for (int i = 7; i >= 0; i--) begin
            idx = base + 3'(i);
            if (vec[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    logic [2:0] next_base;
    logic [3:0] pick_idle;
    logic [3:0] pick_rel;

    assign next_base = sel_q + 3'd1;
    assign pick_idle = rr_pick(req, ptr_q);
    // The owner's bit is already clear on release, so no explicit mask is needed here.
    assign pick_rel  = rr_pick(req, next_base);

`ifdef MUX8_ARB_HOLDLIMIT_EN
    localparam logic [7:0] HOLD_SAT = 8'(MAX_HOLD - 1);

    logic [7:0] hold_q, hold_d;
    logic [3:0] pick_pre;

    assign pick_pre = rr_pick(req & ~(8'b1 << sel_q), next_base);
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
`ifdef MUX8_ARB_HOLDLIMIT_EN
        hold_d  = hold_q;
`endif
        case (state_q)
            IDLE: begin
                // ptr is not touched here; it only moves on release or preemption.
                if (pick_idle[3]) begin
                    state_d = GRANT;
                    sel_d   = pick_idle[2:0];
                    gnt_d   = 8'b1 << pick_idle[2:0];
`ifdef MUX8_ARB_HOLDLIMIT_EN
                    hold_d  = 8'd0;
`endif
                end
            end
            GRANT: begin
                if (!req[sel_q]) begin
                    ptr_d = next_base;
                    if (pick_rel[3]) begin
                        // Back-to-back handover, no bubble cycle.
                        sel_d  = pick_rel[2:0];
                        gnt_d  = 8'b1 << pick_rel[2:0];
`ifdef MUX8_ARB_HOLDLIMIT_EN
                        hold_d = 8'd0;
`endif
                    end else begin
                        state_d = IDLE;
                        gnt_d   = 8'h00;
                    end
                end
`ifdef MUX8_ARB_HOLDLIMIT_EN
                else if (hold_q == HOLD_SAT && pick_pre[3]) begin
                    // Owner hit its tenure limit while someone else waits.
                    ptr_d  = next_base;
                    sel_d  = pick_pre[2:0];
                    gnt_d  = 8'b1 << pick_pre[2:0];
                    hold_d = 8'd0;
                end else if (hold_q != HOLD_SAT) begin
                    hold_d = hold_q + 8'd1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= 3'd0;
            sel_q   <= 3'd0;
            gnt_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
        end
    end

`ifdef MUX8_ARB_HOLDLIMIT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q <= 8'd0;
        end else begin
            hold_q <= hold_d;
        end
    end
`endif

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign sel_valid = (state_q == GRANT);

endmodule

// File: tb/tb_mux8to1_arbiter.sv
// Bench for mux8to1_arbiter: directed scenarios with literal expectations plus
// randomized request traffic compared every cycle against a behavioural model
// that tracks owner / pointer / tenure as plain integers.

module tb_mux8to1_arbiter;

    localparam int MAXH = 4;

    logic       clk;
    logic       reset;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       sel_valid;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    mux8to1_arbiter #(.MAX_HOLD(MAXH)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .gnt       (gnt),
        .sel       (sel),
        .sel_valid (sel_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int m_owner;   // -1 when idle
    int m_ptr;
    int m_hold;    // cycles granted so far minus one
    int m_sel;

    function automatic int pick(input logic [7:0] r, input int p);
        for (int i = 0; i < 8; i++) begin
            if (r[(p + i) % 8]) return (p + i) % 8;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_owner <= -1;
            m_ptr   <= 0;
            m_hold  <= 0;
            m_sel   <= 0;
        end else if (m_owner < 0) begin
            m_owner <= pick(req, m_ptr);
            m_hold  <= 0;
            if (pick(req, m_ptr) >= 0) m_sel <= pick(req, m_ptr);
        end else if (!req[m_owner]) begin
            m_ptr   <= (m_owner + 1) % 8;
            m_owner <= pick(req, (m_owner + 1) % 8);
            m_hold  <= 0;
            if (pick(req, (m_owner + 1) % 8) >= 0) m_sel <= pick(req, (m_owner + 1) % 8);
        end else begin
`ifdef MUX8_ARB_HOLDLIMIT_EN
            if (m_hold == MAXH - 1 && pick(req & ~(8'h01 << m_owner), (m_owner + 1) % 8) >= 0) begin
                m_ptr   <= (m_owner + 1) % 8;
                m_owner <= pick(req & ~(8'h01 << m_owner), (m_owner + 1) % 8);
                m_sel   <= pick(req & ~(8'h01 << m_owner), (m_owner + 1) % 8);
                m_hold  <= 0;
            end else if (m_hold < MAXH - 1) begin
                m_hold <= m_hold + 1;
            end
`else
            m_hold <= m_hold + 1;
`endif
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, sampled on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_gnt", int'(gnt), (m_owner < 0) ? 0 : (1 << m_owner));
            check("model_sel", int'(sel), m_sel);
            check("model_valid", int'(sel_valid), (m_owner < 0) ? 0 : 1);
        end
    end

    // Apply a request vector across one rising edge; return just after the next falling edge.
    task automatic cyc(input logic [7:0] r);
        req = r;
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        #1 reset = 1'b1;
        #1 reset = 1'b0;
    endtask

    logic [7:0] r;
    int exp_h[12];

    initial begin
        reset = 1'b1;
        req   = 8'h00;
        #2;
        check("rst_gnt", int'(gnt), 0);
        check("rst_sel", int'(sel), 0);
        check("rst_valid", int'(sel_valid), 0);
        @(negedge clk);
        reset  = 1'b0;
        chk_en = 1'b1;
        #1;

        // Single requester 3.
        cyc(8'h08);
        check("single_gnt", int'(gnt), 8'h08);
        check("single_sel", int'(sel), 3);
        check("single_valid", int'(sel_valid), 1);
        cyc(8'h08);
        cyc(8'h08);
        check("single_gnt3", int'(gnt), 8'h08);
        cyc(8'h00);
        check("single_rel_gnt", int'(gnt), 0);
        check("single_rel_valid", int'(sel_valid), 0);
        check("single_rel_sel_hold", int'(sel), 3);

        // Full contention from reset: 0..7, two cycles each, no idle gap.
        pulse_reset();
        r = 8'hFF;
        cyc(r);
        check("full_first", int'(sel), 0);
        for (int k = 0; k < 8; k++) begin
            cyc(r);
            check("full_hold_sel", int'(sel), k);
            check("full_hold_valid", int'(sel_valid), 1);
            r[k] = 1'b0;
            cyc(r);
            if (k < 7) begin
                check("full_next_sel", int'(sel), k + 1);
                check("full_next_valid", int'(sel_valid), 1);
            end else begin
                check("full_end_valid", int'(sel_valid), 0);
            end
        end

        // Wrap-around: 6 releases with 7 and 2 pending.
        cyc(8'h40);
        check("wrap_own6", int'(sel), 6);
        cyc(8'h84);
        check("wrap_to7", int'(sel), 7);
        cyc(8'h84);
        cyc(8'h04);
        check("wrap_to2", int'(sel), 2);
        cyc(8'h00);

        // Two requesters held constantly.
`ifdef MUX8_ARB_HOLDLIMIT_EN
        exp_h = '{1, 1, 1, 1, 5, 5, 5, 5, 1, 1, 1, 1};
`else
        exp_h = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
`endif
        pulse_reset();
        for (int i = 0; i < 12; i++) begin
            cyc(8'h22);
            check("hold_seq_sel", int'(sel), exp_h[i]);
        end
        cyc(8'h00);

        // Sole requester is never preempted.
        for (int i = 0; i < 20; i++) begin
            cyc(8'h10);
            check("sole_gnt", int'(gnt), 8'h10);
        end
        cyc(8'h00);

        // Asynchronous reset mid-grant.
        cyc(8'h20);
        check("arst_pre_gnt", int'(gnt), 8'h20);
        check("arst_pre_sel", int'(sel), 5);
        #1 reset = 1'b1;
        #1;
        check("arst_gnt", int'(gnt), 0);
        check("arst_sel", int'(sel), 0);
        check("arst_valid", int'(sel_valid), 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        cyc(8'h01);
        check("arst_after_gnt", int'(gnt), 8'h01);
        cyc(8'h00);

        // Random traffic: requests toggle occasionally so grants have varied tenure.
        r = 8'h00;
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(5) == 0) r[b] = ~r[b];
            end
            if ($urandom_range(299) == 0) pulse_reset();
            cyc(r);
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux8to1_arbiter.md
# mux8to1_arbiter

Round-robin arbiter that shares one `mux8to1` datapath among eight requesters. It samples a request vector, grants exactly one requester at a time, and drives the mux `sel` together with a qualifying valid flag. A grant lasts until the owner drops its request, or until a hold-limit preemption when that feature is compiled in. It sits directly in front of `mux8to1`, with `sel` wired to the mux select.

## Interface
- `MAX_HOLD`, default 16: maximum consecutive grant cycles before preemption. Range 2..255. Used only when `MUX8_ARB_HOLDLIMIT_EN` is defined.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset; clears all state immediately.
- `req` input 8: per-requester request, level-sensitive; bit i is requester i.
- `gnt` output 8: one-hot grant, or all zero when idle; registered.
- `sel` output 3: index of the current or last granted requester; drives `mux8to1.sel`; registered.
- `sel_valid` output 1: high exactly when `gnt` is non-zero; qualifies `sel` and the mux output.

## Operation
- State machine with two states, IDLE and GRANT. Internal round-robin pointer `ptr[2:0]` holds the highest-priority index.
- Arbitration function: the first set bit of the candidate vector, searched from `ptr` upward, wrapping from 7 to 0.
- IDLE:
  - `gnt`=0 and `sel_valid`=0. `sel` holds its last value.
  - If `req`≠0 at an edge, go to GRANT with winner w: `gnt`=1<<w, `sel`=w, `sel_valid`=1, hold count=0.
- GRANT (owner o = `sel`):
  - Release: `req[o]`=0 at an edge. Set `ptr`=o+1 (mod 8) and arbitrate over `req` using the new `ptr`.
  - If that arbitration finds a winner, grant it on the same edge with no bubble cycle and reset the hold count. Otherwise go to IDLE with `gnt`=0.
  - Hold: `req[o]`=1 keeps the grant; the hold count increments and saturates at `MAX_HOLD`-1.
- Simultaneous events: release and new requests on the same edge are resolved in one arbitration. Requests on bits other than the owner never change the grant except by preemption.
- `ptr` advances only on release or preemption; it never advances in IDLE.
- Reset (any time, including mid-grant):
  - `gnt`=8'h00, `sel`=3'd0, `sel_valid`=0, `ptr`=0, state IDLE, hold count=0.
  - After reset deasserts, the first grant is evaluated at the next rising edge.

## Timing
- Grant latency: `req` sampled high at edge k produces `gnt`/`sel` valid after edge k; one cycle from request to grant.
- Release latency: `req[o]` low at edge k means `gnt[o]` is low after edge k; the next owner's grant appears in that same cycle.
- `sel` and `gnt` always change on the same edge and are never inconsistent.
- Downstream `mux8to1` is combinational, so its output is valid in the same cycle as `sel_valid`.
- Minimum tenure is one cycle.

## Configuration
- `MUX8_ARB_HOLDLIMIT_EN` defined: hold-limit preemption is enabled.
  - At an edge where the hold count equals `MAX_HOLD`-1, `req[o]`=1, and any other `req` bit is set, the grant moves to the arbitration winner over `req` with bit o masked.
  - On preemption, `ptr`=o+1 and the hold count resets.
  - If no other request is pending, o keeps the grant and the count stays saturated.
  - An owner therefore holds the grant for at most `MAX_HOLD` cycles while others wait.
- `MUX8_ARB_HOLDLIMIT_EN` undefined: the hold counter and preemption logic are absent. A grant persists until release, and `MAX_HOLD` is ignored.

## Test plan
- Reset: assert `reset` asynchronously mid-grant, with `gnt`=8'h20 and `sel`=5. Required: immediately `gnt`=8'h00, `sel`=0, `sel_valid`=0. After deassertion, `req`=8'h01 gives `gnt`=8'h01 one edge later.
- Single requester: `req`=8'h08 for 3 cycles, then 0. Required: one edge after the request, `gnt`=8'h08, `sel`=3, `sel_valid`=1 for 3 cycles, then `gnt`=0 on the release edge. With `in`=8'hA5, the mux output equals `in[3]`=0 while valid.
- Full contention: from reset, `req`=8'hFF, each owner dropping its bit after 2 granted cycles. Required: grant order 0,1,2,…,7, back-to-back with no idle cycle, 16 cycles total.
- Wrap-around: last owner 6 released, with `req`=8'h84 pending. Required: grant 7 next, then 2 after 7 releases.
- Hold limit on (`MAX_HOLD`=4): `req`=8'h22 held constantly. Required: `sel` sequence 1,1,1,1,5,5,5,5,1,… With the macro off: `sel`=1 indefinitely.
- Hold limit, sole requester: `req`=8'h10 for 20 cycles with the macro on. Required: `gnt`=8'h10 continuously, no preemption.
